// File: rtl/hex_processor_mc.sv
// Multi-cycle Hex core: fetch, data and syscall ports use valid/ready handshakes.
// Instruction and OPR codes follow the Hex encoding (opcode in ir[7:4], operand in ir[3:0]).
module hex_processor_mc #(
  parameter int DATA_WIDTH     = 32,
  parameter int MEM_ADDR_WIDTH = 18,
  parameter int SYSCALL_WIDTH  = 8
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  output logic                      o_f_valid,
  input  logic                      i_f_ready,
  output logic [MEM_ADDR_WIDTH-1:0] o_f_addr,
  input  logic [7:0]                i_f_data,
  output logic                      o_d_valid,
  input  logic                      i_d_ready,
  output logic                      o_d_we,
  output logic [MEM_ADDR_WIDTH-3:0] o_d_addr,
  output logic [DATA_WIDTH-1:0]     o_d_data,
  input  logic [DATA_WIDTH-1:0]     i_d_data,
  output logic                      o_syscall_valid,
  input  logic                      i_syscall_ready,
  output logic [SYSCALL_WIDTH-1:0]  o_syscall,
  output logic                      o_retire,
  output logic                      o_halted
);

  localparam int DW = DATA_WIDTH;
  localparam int AW = MEM_ADDR_WIDTH;
  localparam int WW = MEM_ADDR_WIDTH - 2;

  localparam logic [3:0] LDAM = 4'h0, LDBM = 4'h1, STAM = 4'h2, LDAC = 4'h3,
                         LDBC = 4'h4, LDAP = 4'h5, LDAI = 4'h6, LDBI = 4'h7,
                         STAI = 4'h8, BR   = 4'h9, BRZ  = 4'hA, BRN  = 4'hB,
                         OPR  = 4'hD, PFIX = 4'hE, NFIX = 4'hF;

  localparam logic [3:0] OPR_BRB = 4'h0, OPR_ADD = 4'h1, OPR_SUB = 4'h2, OPR_SVC = 4'h3;

  localparam logic [DW-1:0] NFIX_MASK = {{(DW-8){1'b1}}, 8'h00};

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_EXEC, S_MEM, S_SYS, S_HALT
  } state_t;

  state_t        state, state_n;
  logic [AW-1:0] pc, pc_d, pc_n, br_tgt;
  logic [DW-1:0] areg, areg_d, breg, breg_d, oreg, oreg_d;
  logic [DW-1:0] opr_d, ind_base;
  logic [7:0]    ir, ir_d;
  logic [3:0]    opc, opr;
  logic          is_store, is_indirect;

  assign opc   = ir[7:4];
  assign opr   = ir[3:0];
  assign opr_d = oreg | DW'(opr);

  assign pc_n   = pc + AW'(1);
  assign br_tgt = pc_n + AW'(opr_d);

  assign is_store    = (opc == STAM) || (opc == STAI);
  assign is_indirect = (opc == LDAI) || (opc == LDBI) || (opc == STAI);
  assign ind_base    = (opc == LDAI) ? areg : breg;

  // Address and data come straight from registers that only change on commit,
  // so a stalled request holds steady without extra capture flops.
  assign o_f_addr  = pc;
  assign o_d_addr  = is_indirect ? WW'(ind_base + opr_d) : WW'(opr_d);
  assign o_d_data  = areg;
  assign o_d_we    = (state == S_MEM) && is_store;
  assign o_syscall = areg[SYSCALL_WIDTH-1:0];
  assign o_halted  = (state == S_HALT);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= S_IDLE;
      pc    <= '0;
      areg  <= '0;
      breg  <= '0;
      oreg  <= '0;
      ir    <= '0;
    end else begin
      state <= state_n;
      pc    <= pc_d;
      areg  <= areg_d;
      breg  <= breg_d;
      oreg  <= oreg_d;
      ir    <= ir_d;
    end
  end

  always_comb begin
    state_n         = state;
    pc_d            = pc;
    areg_d          = areg;
    breg_d          = breg;
    oreg_d          = oreg;
    ir_d            = ir;
    o_f_valid       = 1'b0;
    o_d_valid       = 1'b0;
    o_syscall_valid = 1'b0;
    o_retire        = 1'b0;

    case (state)
      S_IDLE: state_n = S_FETCH;

      S_FETCH: begin
        o_f_valid = 1'b1;
        if (i_f_ready) begin
          ir_d    = i_f_data;
          state_n = S_EXEC;
        end
      end

      S_EXEC: begin
        // Default is a single-cycle commit; memory and syscall opcodes defer it.
        o_retire = 1'b1;
        pc_d     = pc_n;
        oreg_d   = '0;
        state_n  = S_FETCH;
        case (opc)
          LDAM, LDBM, STAM, LDAI, LDBI, STAI: begin
            o_retire = 1'b0;
            pc_d     = pc;
            oreg_d   = oreg;
            state_n  = S_MEM;
          end
          LDAC: areg_d = opr_d;
          LDBC: breg_d = opr_d;
          LDAP: areg_d = DW'(br_tgt);
          BR:   pc_d = br_tgt;
          BRZ:  if (areg == '0) pc_d = br_tgt;
          BRN:  if (areg[DW-1]) pc_d = br_tgt;
          OPR: begin
            if (opr_d == DW'(OPR_SVC)) begin
              o_retire = 1'b0;
              pc_d     = pc;
              oreg_d   = oreg;
              state_n  = S_SYS;
            end else if (opr_d == DW'(OPR_BRB)) begin
              pc_d = AW'(breg);
            end else if (opr_d == DW'(OPR_ADD)) begin
              areg_d = areg + breg;
            end else if (opr_d == DW'(OPR_SUB)) begin
              areg_d = areg - breg;
            end
          end
          PFIX: oreg_d = opr_d << 4;
          NFIX: oreg_d = (opr_d << 4) | NFIX_MASK;
          default: ;
        endcase
      end

      S_MEM: begin
        o_d_valid = 1'b1;
        if (i_d_ready) begin
          if ((opc == LDAM) || (opc == LDAI)) begin
            areg_d = i_d_data;
          end else if ((opc == LDBM) || (opc == LDBI)) begin
            breg_d = i_d_data;
          end
          oreg_d   = '0;
          pc_d     = pc_n;
          o_retire = 1'b1;
          state_n  = S_FETCH;
        end
      end

      S_SYS: begin
        o_syscall_valid = 1'b1;
        if (i_syscall_ready) begin
          o_retire = 1'b1;
          oreg_d   = '0;
          pc_d     = pc_n;
          state_n  = (o_syscall == '0) ? S_HALT : S_FETCH;
        end
      end

      S_HALT: ;

      default: state_n = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_hex_processor_mc.sv
// Self-checking bench for hex_processor_mc: program table plus directed handshake sequences.
// Data-port transactions are checked against a scoreboard queue filled when each program is loaded.
module tb_hex_processor_mc;

  localparam int DW = 32;
  localparam int AW = 18;
  localparam int WW = 16;
  localparam int SW = 8;

  logic          i_clk, i_rst;
  logic          o_f_valid, i_f_ready;
  logic [AW-1:0] o_f_addr;
  logic [7:0]    i_f_data;
  logic          o_d_valid, i_d_ready, o_d_we;
  logic [WW-1:0] o_d_addr;
  logic [DW-1:0] o_d_data, i_d_data;
  logic          o_syscall_valid, i_syscall_ready;
  logic [SW-1:0] o_syscall;
  logic          o_retire, o_halted;

  hex_processor_mc #(
    .DATA_WIDTH(DW), .MEM_ADDR_WIDTH(AW), .SYSCALL_WIDTH(SW)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .o_f_valid(o_f_valid), .i_f_ready(i_f_ready), .o_f_addr(o_f_addr), .i_f_data(i_f_data),
    .o_d_valid(o_d_valid), .i_d_ready(i_d_ready), .o_d_we(o_d_we), .o_d_addr(o_d_addr),
    .o_d_data(o_d_data), .i_d_data(i_d_data),
    .o_syscall_valid(o_syscall_valid), .i_syscall_ready(i_syscall_ready), .o_syscall(o_syscall),
    .o_retire(o_retire), .o_halted(o_halted)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  logic [7:0]  imem [256];
  logic [31:0] dmem [256];
  assign i_f_data = imem[o_f_addr[7:0]];
  assign i_d_data = dmem[o_d_addr[7:0]];

  typedef struct packed {
    logic        we;
    logic [15:0] addr;
    logic [31:0] data;
  } xact_t;

  typedef struct {
    logic [127:0]    prog;
    int              n;
    int              ret;
    int              nx;
    xact_t [2:0]     xs;
  } vec_t;

  xact_t exp_q[$];
  xact_t mon_x;
  vec_t  vecs[$];
  vec_t  vb, vc;

  int errors = 0;
  int checks = 0;
  int f_wait, d_wait, s_wait, f_cnt, d_cnt, s_cnt;
  int n_ret, d_vcyc, s_vcyc1;
  logic        f_pend, d_pend, s_pend;
  logic [63:0] f_snap, d_snap, s_snap;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int pick(input int cfg);
    return (cfg < 0) ? int'($urandom_range(2, 0)) : cfg;
  endfunction

  function automatic xact_t xa(input logic we, input logic [15:0] a, input logic [31:0] d);
    xact_t x;
    x.we = we; x.addr = a; x.data = d;
    return x;
  endfunction

  function automatic vec_t mk_vec(input logic [127:0] prog, input int n, input int ret,
                                  input int nx, input xact_t x0, input xact_t x1, input xact_t x2);
    vec_t v;
    v.prog = prog; v.n = n; v.ret = ret; v.nx = nx;
    v.xs[0] = x0; v.xs[1] = x1; v.xs[2] = x2;
    return v;
  endfunction

  task automatic add_vec(input logic [127:0] prog, input int n, input int ret,
                         input int nx, input xact_t x0, input xact_t x1, input xact_t x2);
    vecs.push_back(mk_vec(prog, n, ret, nx, x0, x1, x2));
  endtask

  // Program bytes are right-aligned in prog; byte 0 is the most significant of the n used.
  task automatic load_vec(input vec_t v);
    logic [127:0] p;
    p = v.prog;
    exp_q.delete();
    for (int a = 0; a < 256; a++) begin
      imem[a] = 8'hC0;
      dmem[a] = 32'hA500_0000 + a;
    end
    for (int b = 0; b < v.n; b++) imem[b] = p[8*(v.n-1-b) +: 8];
    for (int j = 0; j < v.nx; j++) exp_q.push_back(v.xs[j]);
    f_cnt = pick(f_wait);
    d_cnt = pick(d_wait);
    s_cnt = pick(s_wait);
  endtask

  task automatic do_reset();
    @(posedge i_clk); #1;
    i_rst   = 1'b1;
    n_ret   = 0;
    d_vcyc  = 0;
    s_vcyc1 = 0;
    repeat (2) begin @(posedge i_clk); #1; end
  endtask

  task automatic release_rst();
    @(posedge i_clk); #1;
    i_rst = 1'b0;
  endtask

  task automatic wait_halt(input int ret, input string tag);
    int cyc;
    cyc = 0;
    while (!o_halted && cyc < 600) begin
      @(posedge i_clk); #1;
      cyc++;
    end
    chk({tag, "_halted"}, 64'(o_halted), 64'd1);
    chk({tag, "_sb_empty"}, 64'(exp_q.size()), 64'd0);
    chk({tag, "_retires"}, 64'(n_ret), 64'(ret));
    repeat (4) begin
      @(posedge i_clk); #1;
      chk({tag, "_quiet"}, {59'd0, o_f_valid, o_d_valid, o_syscall_valid, o_retire, o_halted}, 64'd1);
    end
  endtask

  // Port responder and monitor: readies are driven on the falling edge, then everything
  // is sampled 2 time units later, well before the next rising edge.
  initial begin
    forever begin
      @(negedge i_clk);
      if (i_rst) begin
        i_f_ready = 1'b0; i_d_ready = 1'b0; i_syscall_ready = 1'b0;
        f_pend = 1'b0; d_pend = 1'b0; s_pend = 1'b0;
      end else begin
        if (o_f_valid) begin
          if (f_cnt > 0) begin i_f_ready = 1'b0; f_cnt--; end
          else begin i_f_ready = 1'b1; f_cnt = pick(f_wait); end
        end else i_f_ready = 1'b0;
        if (o_d_valid) begin
          if (d_cnt > 0) begin i_d_ready = 1'b0; d_cnt--; end
          else begin i_d_ready = 1'b1; d_cnt = pick(d_wait); end
        end else i_d_ready = 1'b0;
        if (o_syscall_valid) begin
          if (s_cnt > 0) begin i_syscall_ready = 1'b0; s_cnt--; end
          else begin i_syscall_ready = 1'b1; s_cnt = pick(s_wait); end
        end else i_syscall_ready = 1'b0;
        #2;
        if (!i_rst) begin
          if (f_pend) chk("f_stable", {45'd0, o_f_valid, o_f_addr}, f_snap);
          if (d_pend) chk("d_stable", {14'd0, o_d_valid, o_d_we, o_d_addr, o_d_data}, d_snap);
          if (s_pend) chk("s_stable", {55'd0, o_syscall_valid, o_syscall}, s_snap);
          f_pend = o_f_valid && !i_f_ready;
          d_pend = o_d_valid && !i_d_ready;
          s_pend = o_syscall_valid && !i_syscall_ready;
          f_snap = {45'd0, o_f_valid, o_f_addr};
          d_snap = {14'd0, o_d_valid, o_d_we, o_d_addr, o_d_data};
          s_snap = {55'd0, o_syscall_valid, o_syscall};
          if (o_retire) n_ret++;
          if (o_d_valid) d_vcyc++;
          if (o_syscall_valid && o_syscall == 8'd1) s_vcyc1++;
          if (o_d_valid && i_d_ready) begin
            if (exp_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL d_unexpected: got we=%0b addr=0x%0h, expected no transaction", o_d_we, o_d_addr);
            end else begin
              mon_x = exp_q.pop_front();
              chk("d_we", 64'(o_d_we), 64'(mon_x.we));
              chk("d_addr", 64'(o_d_addr), 64'(mon_x.addr));
              if (mon_x.we) chk("d_data", 64'(o_d_data), 64'(mon_x.data));
            end
            if (o_d_we) dmem[o_d_addr[7:0]] = o_d_data;
          end
        end
      end
    end
  end

  initial begin
    i_rst = 1'b1;
    i_f_ready = 1'b0; i_d_ready = 1'b0; i_syscall_ready = 1'b0;
    f_wait = 0; d_wait = 0; s_wait = 0;
    f_cnt = 0; d_cnt = 0; s_cnt = 0;
    n_ret = 0; d_vcyc = 0; s_vcyc1 = 0;

    add_vec(128'hE1322030D3, 5, 5, 1, xa(1, 16'd0, 32'h12), '0, '0);
    add_vec(128'hF1302030D3, 5, 5, 1, xa(1, 16'd0, 32'hFFFFFF10), '0, '0);
    add_vec(128'h3543D121D22230D3, 8, 8, 2, xa(1, 16'd1, 32'd8), xa(1, 16'd2, 32'd5), '0);
    add_vec(128'h3030303092_3F3E37_2030D3, 11, 9, 1, xa(1, 16'd0, 32'd7), '0, '0);
    add_vec(128'h35A2362030D3, 6, 6, 1, xa(1, 16'd0, 32'd6), '0, '0);
    add_vec(128'h30A23F3F392030D3, 8, 6, 1, xa(1, 16'd0, 32'd9), '0, '0);
    add_vec(128'hE8E0E0E0E0E0E030B1202130D3, 13, 12, 1, xa(1, 16'd1, 32'h80000000), '0, '0);
    add_vec(128'h30522030D3, 5, 5, 1, xa(1, 16'd0, 32'd4), '0, '0);
    add_vec(128'h052030D3, 4, 4, 2, xa(0, 16'd5, 32'd0), xa(1, 16'd0, 32'hA5000005), '0);
    add_vec(128'hE3EFEFEF4F7130D12330D3, 11, 11, 2, xa(0, 16'd0, 32'd0), xa(1, 16'd3, 32'hA5000000), '0);
    add_vec(128'h42E737813162243_0D3, 9, 9, 3, xa(1, 16'd3, 32'h77), xa(0, 16'd3, 32'd0), xa(1, 16'd4, 32'h77));
    add_vec(128'h45D03F3F3F3A2030D3, 9, 6, 1, xa(1, 16'd0, 32'hA), '0, '0);
    add_vec(128'hE1C5372030D3, 6, 6, 1, xa(1, 16'd0, 32'd7), '0, '0);
    vb = mk_vec(128'hEA3B2330D3, 5, 5, 1, xa(1, 16'd3, 32'hAB), '0, '0);
    vc = mk_vec(128'h31D330D3, 4, 4, 0, '0, '0, '0);

    // Reset values, retire timing and fetch address order with zero-wait ports.
    do_reset();
    load_vec(vecs[0]);
    chk("reset_outputs", {58'd0, o_f_valid, o_d_valid, o_d_we, o_syscall_valid, o_retire, o_halted}, 64'd0);
    release_rst();
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("retire_k%0d", k), 64'(o_retire), 64'((k == 2) || (k == 4)));
      chk($sformatf("f_valid_k%0d", k), 64'(o_f_valid), 64'((k == 1) || (k == 3) || (k == 5)));
      if (k == 1 || k == 3 || k == 5) chk($sformatf("f_addr_k%0d", k), 64'(o_f_addr), 64'((k - 1) / 2));
      @(posedge i_clk); #1;
    end
    wait_halt(5, "seq_a");

    for (int i = 0; i < vecs.size(); i++) begin
      f_wait = (i % 2 == 1) ? -1 : 0;
      d_wait = f_wait;
      s_wait = f_wait;
      do_reset();
      load_vec(vecs[i]);
      release_rst();
      wait_halt(vecs[i].ret, $sformatf("vec%0d", i));
    end

    // Store held off for three cycles: one stable request, one retire.
    f_wait = 0; d_wait = 0; s_wait = 0;
    do_reset();
    load_vec(vb);
    d_cnt = 3;
    release_rst();
    wait_halt(5, "stam_wait");
    chk("stam_wait_valid_cycles", 64'(d_vcyc), 64'd4);

    // Non-exit syscall with a slow host, then an exit syscall.
    do_reset();
    load_vec(vc);
    s_cnt = 2;
    release_rst();
    wait_halt(4, "svc_wait");
    chk("svc_wait_valid_cycles", 64'(s_vcyc1), 64'd3);

    // Reset while a fetch is stalled: request drops at once and restarts from pc 0.
    do_reset();
    load_vec(vecs[0]);
    f_cnt = 6;
    release_rst();
    repeat (3) begin @(posedge i_clk); #1; end
    chk("rst_fetch_pending", 64'(o_f_valid), 64'd1);
    i_rst = 1'b1;
    #1;
    chk("rst_async_drop", {62'd0, o_f_valid, o_retire}, 64'd0);
    n_ret = 0; d_vcyc = 0; s_vcyc1 = 0;
    repeat (2) begin @(posedge i_clk); #1; end
    f_cnt = 0;
    i_rst = 1'b0;
    begin
      int cyc;
      cyc = 0;
      while (!o_f_valid && cyc < 10) begin
        @(posedge i_clk); #1;
        cyc++;
      end
    end
    chk("rst_restart_valid", 64'(o_f_valid), 64'd1);
    chk("rst_restart_addr", 64'(o_f_addr), 64'd0);
    wait_halt(5, "rst_mid");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hex_processor_mc.md
Name: hex_processor_mc

Overview:
- Multi-cycle, parametrised Hex core. Successor to the single-cycle processor.
- Replaces the zero-latency fetch and data ports with valid/ready handshakes, so it tolerates wait-stated memories and bus fabrics.
- Adds a blocking syscall handshake, an exit/halt state and a retire strobe.
- Sits between the instruction memory, data memory and syscall host in the simulation top level. Uses the hex_pkg opcode and OPR encodings.

Parameters:
- DATA_WIDTH, 32, width of areg/breg/oreg and data bus (>=16).
- MEM_ADDR_WIDTH, 18, instruction (byte) address width. Word address width is MEM_ADDR_WIDTH-2.
- SYSCALL_WIDTH, 8, width of o_syscall, taken from areg LSBs.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset
- o_f_valid  out  1  fetch request
- i_f_ready  in  1  fetch accept; i_f_data valid this cycle
- o_f_addr  out  MEM_ADDR_WIDTH  pc
- i_f_data  in  8  instruction {opc[7:4], opr[3:0]}
- o_d_valid  out  1  data request
- i_d_ready  in  1  data accept; i_d_data valid this cycle for loads
- o_d_we  out  1  store
- o_d_addr  out  MEM_ADDR_WIDTH-2  word address
- o_d_data  out  DATA_WIDTH  store data
- i_d_data  in  DATA_WIDTH  load data
- o_syscall_valid  out  1  syscall request
- i_syscall_ready  in  1  host done
- o_syscall  out  SYSCALL_WIDTH  areg[SYSCALL_WIDTH-1:0]
- o_retire  out  1  one-cycle pulse per completed instruction
- o_halted  out  1  exit syscall completed

Behaviour:
- Reset: i_rst is asynchronous, active-high; clock is i_clk.
  - On reset: pc, areg, breg, oreg, ir = 0; state = IDLE.
  - All outputs 0: o_f_valid, o_d_valid, o_d_we, o_syscall_valid, o_retire, o_halted.
  - Reset mid-transaction drops any outstanding request immediately; no retire.
- State machine: IDLE, FETCH, EXEC, MEM, SYS, HALT.
  - IDLE -> FETCH unconditionally.
  - FETCH: o_f_valid=1, o_f_addr=pc. On i_f_ready, capture i_f_data into ir, -> EXEC. Otherwise hold.
  - EXEC: decode ir; opr_d = oreg | zero-extended opr.
    - Memory opcodes (LDAM, LDBM, STAM, LDAI, LDBI, STAI) -> MEM.
    - OPR/SVC -> SYS.
    - All others commit, pulse o_retire, -> FETCH.
  - MEM: o_d_valid=1; o_d_we=1 for STAM/STAI; o_d_data=areg.
    - Direct address: opr_d truncated to MEM_ADDR_WIDTH-2.
    - Indirect address: (areg for LDAI, breg for LDBI/STAI) + opr_d, truncated to MEM_ADDR_WIDTH-2 (wraps).
    - On i_d_ready: loads write areg/breg from i_d_data; oreg=0; pc+=1; retire; -> FETCH.
  - SYS: o_syscall_valid=1. On i_syscall_ready: retire, oreg=0, pc+=1.
    - If o_syscall==0 (exit), -> HALT; otherwise -> FETCH.
  - HALT: o_halted=1; no requests issued; left only by reset.
- Request stability: while o_*_valid=1 and ready=0, valid, address, we and data hold constant.
- Commit rules (pc_n = pc+1, width MEM_ADDR_WIDTH, wraps):
  - Branch offset is opr_d[MEM_ADDR_WIDTH-1:0] as two's complement.
  - BR: pc = pc_n + offset.
  - BRZ: taken if areg==0.
  - BRN: taken if areg[DATA_WIDTH-1]==1.
  - Not taken: pc = pc_n.
  - OPR BRB: pc = breg[MEM_ADDR_WIDTH-1:0].
  - OPR ADD / SUB: areg = areg ± breg mod 2^DATA_WIDTH.
  - LDAC / LDBC: areg / breg = opr_d.
  - LDAP: areg = zero-extended (pc_n + offset).
  - PFIX: oreg = opr_d << 4.
  - NFIX: oreg = (opr_d << 4) | ~(2^8 - 1) (bits [DATA_WIDTH-1:8] set).
  - Every non-prefix instruction clears oreg.
  - Undefined opcode or OPR code: NOP (pc_n, oreg=0, retire).
- Latency with zero-wait ports:
  - 2 cycles per ALU/branch/prefix instruction.
  - 3 cycles per memory or syscall instruction.
  - Each wait cycle adds 1.
- o_retire is registered-free combinational from the handshake/commit condition. It is never asserted in IDLE or HALT.

Test Plan:
- Reset, then ready always 1, program 0xE1,0x32 (pfix 1; ldac 2) -> areg=0x12, oreg=0; o_retire pulses at cycles 2 and 4 after IDLE; o_f_addr sequence 0,1,2.
- Program 0xF1,0x30 (nfix 1; ldac 0) -> areg=0xFFFFFF10.
- Branch: pc=4, ir=0x92 (br 2) -> next o_f_addr=7. BRZ with areg=5 -> o_f_addr=pc+1. BRN with areg=0x80000000 -> taken.
- Wait states: areg=0xAB, instr 0x23 (stam 3), i_d_ready low 3 cycles -> o_d_valid high 4 cycles; addr=3, we=1, data=0xAB stable throughout; single retire.
- Indirect load: breg=0x3FFFF, ldbi 1 -> o_d_addr wraps to 0x0000; breg = i_d_data on ready.
- Syscalls: areg=1, 0xD3 with i_syscall_ready delayed 2 cycles -> o_syscall=1 held 3 cycles, then FETCH. areg=0, 0xD3 -> HALT, o_halted=1, no further o_f_valid. Assert i_rst mid-FETCH wait -> o_f_valid drops asynchronously, restarts at pc=0.
